// File: rtl/rom_image_crc_checker.sv
// ROM image checker: drains the flash read FIFO, computes CRC-32 (IEEE, reflected) and
// compares byte count and CRC against targets. Optional ROM_CHECK_SUM8_EN adds a sum8 output.
module rom_image_crc_checker #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [31:0] CRC_INIT       = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT     = 32'hFFFF_FFFF
) (
    input  logic        system_clk,
    input  logic        system_reset,
    input  logic        start,
    input  logic [31:0] byte_target,
    input  logic [31:0] expected_crc,
    input  logic        read_finish,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        err_short,
    output logic [31:0] crc_value,
    output logic [31:0] bytes_checked,
`ifdef ROM_CHECK_SUM8_EN
    output logic [7:0]  sum8,
`endif
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state, next_state;
    logic [31:0] target_q;
    logic [31:0] exp_crc_q;
    logic [31:0] issued_cnt;
    logic [31:0] timeout_cnt;
    logic [31:0] crc_reg;
    logic        valid_q;
    logic        rd_en_c;
    logic        short_hit;
    logic [31:0] crc_final;

    // FIFO handshake: a byte is transferred when fifo_rd_en is high at a clock edge
    // (only issued while !fifo_empty); its data is on fifo_data the following cycle,
    // which valid_q marks.
    assign fifo_rd_en = rd_en_c;
    assign fsm_state  = state;
    assign crc_final  = crc_reg ^ CRC_XOROUT;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        next_state = state;
        rd_en_c    = 1'b0;
        short_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (byte_target == 32'd0) ? FINISH : RUN;
                end
            end
            RUN: begin
                rd_en_c   = !fifo_empty && (issued_cnt < target_q);
                short_hit = fifo_empty && (read_finish || (timeout_cnt == TIMEOUT_CYCLES));
                if (rd_en_c && (issued_cnt + 32'd1 == target_q)) begin
                    next_state = DRAIN;
                end else if (short_hit) begin
                    // Any in-flight byte is absorbed on this same edge.
                    next_state = FINISH;
                end
            end
            DRAIN: begin
                // The final strobe was issued last cycle, so its byte lands on this edge.
                next_state = FINISH;
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state         <= IDLE;
            target_q      <= 32'd0;
            exp_crc_q     <= 32'd0;
            issued_cnt    <= 32'd0;
            timeout_cnt   <= 32'd0;
            crc_reg       <= CRC_INIT;
            valid_q       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            crc_ok        <= 1'b0;
            err_short     <= 1'b0;
            crc_value     <= 32'd0;
            bytes_checked <= 32'd0;
`ifdef ROM_CHECK_SUM8_EN
            sum8          <= 8'd0;
`endif
        end else begin
            state   <= next_state;
            valid_q <= rd_en_c;
            done    <= 1'b0;

            if (rd_en_c) begin
                issued_cnt <= issued_cnt + 32'd1;
            end

            if (rd_en_c) begin
                timeout_cnt <= 32'd0;
            end else if (state == RUN && fifo_empty) begin
                timeout_cnt <= timeout_cnt + 32'd1;
            end

            if (valid_q) begin
                crc_reg       <= crc_step(crc_reg, fifo_data);
                bytes_checked <= bytes_checked + 32'd1;
`ifdef ROM_CHECK_SUM8_EN
                sum8          <= sum8 + fifo_data;
`endif
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        target_q      <= byte_target;
                        exp_crc_q     <= expected_crc;
                        crc_ok        <= 1'b0;
                        err_short     <= 1'b0;
                        bytes_checked <= 32'd0;
                        crc_reg       <= CRC_INIT;
                        issued_cnt    <= 32'd0;
                        timeout_cnt   <= 32'd0;
                        busy          <= 1'b1;
`ifdef ROM_CHECK_SUM8_EN
                        sum8          <= 8'd0;
`endif
                    end
                end
                RUN: begin
                    if (short_hit && next_state == FINISH) begin
                        err_short <= 1'b1;
                    end
                end
                DRAIN: begin
                end
                FINISH: begin
                    crc_value <= crc_final;
                    crc_ok    <= !err_short && (crc_final == exp_crc_q);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_image_crc_checker.sv
// Bench for rom_image_crc_checker: FIFO model, CRC reference model and a per-cycle
// compare process fed by an expected-result queue.
module tb_rom_image_crc_checker;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] byte_target = 32'd0;
    logic [31:0] expected_crc = 32'd0;
    logic        read_finish = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'd0;
    logic        fifo_rd_en;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        err_short;
    logic [31:0] crc_value;
    logic [31:0] bytes_checked;
    logic [1:0]  fsm_state;
`ifdef ROM_CHECK_SUM8_EN
    logic [7:0]  sum8;
`endif

    always #5 clk = ~clk;

    rom_image_crc_checker #(
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .system_clk   (clk),
        .system_reset (rst),
        .start        (start),
        .byte_target  (byte_target),
        .expected_crc (expected_crc),
        .read_finish  (read_finish),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .busy         (busy),
        .done         (done),
        .crc_ok       (crc_ok),
        .err_short    (err_short),
        .crc_value    (crc_value),
        .bytes_checked(bytes_checked),
`ifdef ROM_CHECK_SUM8_EN
        .sum8         (sum8),
`endif
        .fsm_state    (fsm_state)
    );

    // Scoreboard entries: {sum8, crc_ok, err_short, crc_value, bytes_checked}
    logic [73:0] exp_q[$];
    logic [7:0]  fifo_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    int          start_cyc = 0;
    int          last_lat = 0;
    int          probe_kind = 0;
    logic [31:0] probe_val = 32'd0;
    logic        rd_q = 1'b0;
    bit          pinned = 1'b0;

    // Reference CRC: message as an LSB-first bit stream through the normal-form
    // polynomial, result bit-reversed and complemented.
    function automatic logic [31:0] model_crc(input bq_t d, input int n);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ d[i][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int b = 0; b < 32; b++) r[b] = c[31 - b];
        return r ^ 32'hFFFF_FFFF;
    endfunction

    function automatic logic [7:0] model_sum(input bq_t d, input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s = s + int'(d[i]);
        return 8'(s % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_q <= fifo_rd_en;
    end

    // Compare process plus FIFO model (non-show-ahead: data appears the cycle after the strobe).
    always @(negedge clk) begin
        logic [73:0] e;
        bq_t         pin_msg;
        if (!pinned) begin
            pinned = 1'b1;
            for (int i = 0; i < 9; i++) pin_msg.push_back(8'(8'h31 + i));
            check("model_pin_crc", model_crc(pin_msg, 9), 32'hCBF4_3926);
            check("model_pin_sum", {24'd0, model_sum(pin_msg, 9)}, 32'h0000_00DD);
        end
        if (start && !busy && !rst) begin
            pop_cnt   = 0;
            start_cyc = cyc;
        end
        if (busy) check("bytes_checked_track", bytes_checked, pop_cnt);
        if (done) begin
            done_cnt = done_cnt + 1;
            last_lat = cyc - start_cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bytes_checked", bytes_checked, e[31:0]);
                check("crc_value", crc_value, e[63:32]);
                check("err_short", {31'd0, err_short}, {31'd0, e[64]});
                check("crc_ok", {31'd0, crc_ok}, {31'd0, e[65]});
                check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef ROM_CHECK_SUM8_EN
                check("sum8", {24'd0, sum8}, {24'd0, e[73:66]});
`endif
            end
        end
        case (probe_kind)
            1: begin
                check("idle_busy", {31'd0, busy}, 32'd0);
                check("idle_done", {31'd0, done}, 32'd0);
                check("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
                check("idle_crc_ok", {31'd0, crc_ok}, 32'd0);
                check("idle_err_short", {31'd0, err_short}, 32'd0);
                check("idle_crc_value", crc_value, 32'd0);
                check("idle_bytes_checked", bytes_checked, 32'd0);
            end
            2: check("fifo_leftover", fifo_q.size(), probe_val);
            3: check("wait_timeout", 32'd0, 32'd1);
            4: check("done_latency", last_lat, probe_val);
            5: check("crc_literal", crc_value, probe_val);
            6: check("pending_expect", exp_q.size(), 32'd0);
            default: ;
        endcase
        if (rd_q) begin
            if (fifo_q.size() == 0) begin
                check("fifo_underflow", 32'd1, 32'd0);
            end else begin
                fifo_data = fifo_q.pop_front();
                pop_cnt   = pop_cnt + 1;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int kind, input logic [31:0] val);
        probe_kind = kind;
        probe_val  = val;
        tick();
        probe_kind = 0;
    endtask

    task automatic push_bytes(input bq_t d);
        foreach (d[i]) fifo_q.push_back(d[i]);
    endtask

    task automatic do_start(input logic [31:0] target, input logic [31:0] ref_crc);
        byte_target  = target;
        expected_crc = ref_crc;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic expect_run(input bq_t d, input int target, input logic [31:0] ref_crc);
        int          n;
        logic        err;
        logic        ok;
        logic [31:0] c;
        logic [7:0]  s;
        n   = (d.size() < target) ? d.size() : target;
        err = (d.size() < target);
        c   = model_crc(d, n);
        s   = model_sum(d, n);
        ok  = !err && (c == ref_crc);
        exp_q.push_back({s, ok, err, c, 32'(n)});
    endtask

    task automatic wait_done(input int max_cycles);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (done_cnt != base) seen = 1'b1;
        end
        if (!seen) probe(3, 32'd0);
    endtask

    initial begin
        bq_t msg;
        bq_t d10;
        bq_t d8;
        bq_t d3;
        bq_t none;
        int  k;
        for (int i = 0; i < 9; i++) msg.push_back(8'(8'h31 + i));
        for (int i = 0; i < 10; i++) d10.push_back(8'(8'hA0 + 7 * i));
        for (int i = 0; i < 8; i++) d8.push_back(8'(16 * i + 1));
        d3.push_back(8'hDE);
        d3.push_back(8'hAD);
        d3.push_back(8'hBE);

        // Reset: outputs zero during and after reset
        tick();
        tick();
        probe(1, 32'd0);
        rst = 1'b0;
        probe(1, 32'd0);

        // "123456789" with matching CRC; done 12 cycles after start
        push_bytes(msg);
        tick();
        expect_run(msg, 9, 32'hCBF4_3926);
        do_start(32'd9, 32'hCBF4_3926);
        wait_done(50);
        probe(4, 32'd12);
        probe(5, 32'hCBF4_3926);

        // Same stream, wrong reference
        push_bytes(msg);
        tick();
        expect_run(msg, 9, 32'h0000_0000);
        do_start(32'd9, 32'h0000_0000);
        wait_done(50);
        probe(5, 32'hCBF4_3926);

        // Short stream: 10 of 16 bytes then read_finish
        push_bytes(d10);
        read_finish = 1'b1;
        tick();
        expect_run(d10, 16, model_crc(d10, 10));
        do_start(32'd16, model_crc(d10, 10));
        wait_done(60);
        read_finish = 1'b0;
        tick();

        // Timeout with an empty FIFO (TIMEOUT_CYCLES = 100)
        expect_run(none, 4, 32'd0);
        do_start(32'd4, 32'd0);
        wait_done(200);
        probe(4, 32'd103);

        // Extra bytes stay in the FIFO
        push_bytes(d8);
        tick();
        expect_run(d8, 4, model_crc(d8, 4));
        do_start(32'd4, model_crc(d8, 4));
        wait_done(40);
        probe(2, 32'd4);
        fifo_q.delete();
        tick();

        // Zero-length target
        expect_run(none, 0, 32'd0);
        do_start(32'd0, 32'd0);
        wait_done(10);
        probe(4, 32'd2);

        // Data arrives in the same cycle read_finish rises: no error
        expect_run(d3, 3, model_crc(d3, 3));
        do_start(32'd3, model_crc(d3, 3));
        repeat (5) tick();
        push_bytes(d3);
        read_finish = 1'b1;
        wait_done(40);
        read_finish = 1'b0;
        tick();

        // Reset mid-RUN after 3 bytes: aborts with no done
        do_start(32'd8, 32'd0);
        k = 0;
        while (bytes_checked != 32'd3 && k < 60) begin
            if (k % 3 == 0) fifo_q.push_back(8'(8'h50 + k));
            tick();
            k++;
        end
        if (k >= 60) probe(3, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe(1, 32'd0);
        repeat (3) tick();
        fifo_q.delete();
        tick();
        tick();

        // Clean rerun; a start pulse mid-run must be ignored
        push_bytes(msg);
        tick();
        expect_run(msg, 9, 32'hCBF4_3926);
        do_start(32'd9, 32'hCBF4_3926);
        repeat (3) tick();
        byte_target  = 32'd2;
        expected_crc = 32'd0;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        wait_done(50);
        probe(4, 32'd12);

        repeat (3) tick();
        probe(6, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_image_crc_checker.md
Name: rom_image_crc_checker

Overview:
- Drains the byte FIFO at the output of the SPI flash read stage and computes a CRC-32 (IEEE 802.3, reflected) over the ROM image byte stream.
- Counts the consumed bytes and compares both the count and the CRC against the programmed targets.
- Reports pass/fail to the board control logic that drives busy_n/completed_n. Sits directly downstream of the flash read FIFO, on system_clk.

Parameters:
- TIMEOUT_CYCLES, 32'd1_000_000, max idle cycles with FIFO empty while a check is running before error.
- CRC_INIT, 32'hFFFF_FFFF, CRC register preset on start.
- CRC_XOROUT, 32'hFFFF_FFFF, value XORed into the CRC register to form crc_value.

Ports:
- system_clk  in  1  single clock for the block.
- system_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a check (accepted only in IDLE).
- byte_target  in  32  bytes to consume; sampled on start; 0 is allowed.
- expected_crc  in  32  reference CRC; sampled on start.
- read_finish  in  1  level from the read stage; no more bytes will be written to the FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd_en (non-show-ahead).
- fifo_rd_en  out  1  FIFO read strobe.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse at completion (pass or fail).
- crc_ok  out  1  held result: count reached and CRC match.
- err_short  out  1  held: stream ended or timed out before byte_target.
- crc_value  out  32  final CRC (register XOR CRC_XOROUT), held after done.
- bytes_checked  out  32  bytes consumed so far.

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register = CRC_INIT; timeout counter 0. Reset mid-check aborts immediately; no done pulse.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - On start, latch byte_target and expected_crc, clear crc_ok, err_short and bytes_checked, load CRC_INIT, set busy.
  - If byte_target == 0, go to FINISH; otherwise go to RUN.
  - start outside IDLE is ignored.
- RUN:
  - fifo_rd_en = !fifo_empty && (issued_count < target). issued_count counts strobes issued; at most one read per cycle.
  - A one-cycle valid pipe (rd_en delayed) marks fifo_data valid.
  - On each valid byte: update CRC by byte-wise reflected step (poly 32'hEDB88320, LSB first, 8 shifts combinational) and increment bytes_checked.
  - Sustained throughput is 1 byte/cycle; latency from rd_en to bytes_checked increment is 2 cycles.
- DRAIN: entered when issued_count == target; waits for the final valid byte, then goes to FINISH.
- Timeout counter: clears on every rd_en and increments each RUN cycle with fifo_empty.
- Short stream: in RUN, if (read_finish && fifo_empty) or timeout counter == TIMEOUT_CYCLES, set err_short and go to FINISH once any in-flight byte is absorbed.
- FINISH (one cycle):
  - crc_value = crc_reg ^ CRC_XOROUT.
  - crc_ok = !err_short && (crc_value == expected_crc latched).
  - done pulses 1, busy drops, return to IDLE. crc_ok, err_short and crc_value hold until the next start.
- Extra bytes: bytes left in the FIFO after target is reached are not read.
- Simultaneous events: fifo_empty deasserting in the same cycle as read_finish counts as data available; read proceeds, no error.
- bytes_checked is 32-bit and does not wrap within legal targets.

Optional Feature:
- Macro: ROM_CHECK_SUM8_EN.
- Defined: adds output sum8 [7:0], the modulo-256 additive sum of all consumed bytes. It clears on start and updates on the same cycle as the CRC, giving a fast cross-check.
- Not defined: port absent, no adder logic; all other behaviour identical.

Test Plan:
- Bytes "123456789" (0x31..0x39), byte_target=9, expected_crc=32'hCBF43926 -> done after last byte+1, crc_ok=1, crc_value=32'hCBF43926, bytes_checked=9 (sum8=8'hDD if macro defined).
- Same stream, expected_crc=32'h00000000 -> done, crc_ok=0, err_short=0, crc_value=32'hCBF43926.
- byte_target=16, FIFO supplies 10 bytes then read_finish=1 with fifo_empty=1 -> err_short=1, crc_ok=0, bytes_checked=10, done pulses once.
- byte_target=4, FIFO stays empty, TIMEOUT_CYCLES=100 -> err_short=1 at cycle ~101 after start, fifo_rd_en never asserted.
- FIFO holds 8 bytes, byte_target=4 -> exactly 4 rd_en strobes, 4 bytes remain in FIFO, bytes_checked=4.
- system_reset asserted mid-RUN after 3 bytes -> next cycle busy=0, bytes_checked=0, no done; new start then runs cleanly.
